// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline front end: machine word, fetch FSM states, word size.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        REDIR  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t WORD_BYTES = 32'd4;

    // Redirect targets are word addresses; the low two bits are dropped on capture.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of icache, hazard, redirect and IF/ID signals seen by the fetch stage.
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t iload;
    logic  iREN;
    word_t iaddr;
    logic  stall;
    logic  redir_valid;
    word_t redir_pc;
    logic  halt;
    word_t instru;
    word_t PC;
    word_t nPC;
    logic  deen;
    word_t fetch_count;

    modport master (
        input  ihit, iload, stall, redir_valid, redir_pc, halt,
        output iREN, iaddr, instru, PC, nPC, deen, fetch_count
    );

    modport slave (
        output ihit, iload, stall, redir_valid, redir_pc, halt,
        input  iREN, iaddr, instru, PC, nPC, deen, fetch_count
    );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with load (redirect) taking priority over increment.
module pc_reg
    import cpu_types_pkg::*;
#(
    parameter word_t PC_RESET = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load_i,
    input  word_t load_val_i,
    input  logic  inc_i,
    output word_t pc_o
);

    word_t pc_q;
    word_t pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + WORD_BYTES;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: issues icache reads at the PC, delivers hits to IF/ID, absorbs redirects and halt.
//
//   state  | meaning
//   FETCH  | normal fetch; a hit delivers unless stalled or redirected
//   REDIR  | icache miss outstanding with a redirect waiting in pend_pc_q
//   HALTED | fetch stopped until reset
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_RESET = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            nRST,
    fetch_stage_if.master   fe_if
);

    fetch_state_t state_q, state_d;
    word_t        pend_pc_q, pend_pc_d;
    word_t        fetch_count_q, fetch_count_d;

    word_t pc_r;
    word_t redir_pc_al;
    logic  pc_load;
    word_t pc_load_val;
    logic  pc_inc;
    logic  deen_raw;

    assign redir_pc_al = align_word(fe_if.redir_pc);

    pc_reg #(
        .PC_RESET (PC_RESET)
    ) u_pc_reg (
        .CLK        (CLK),
        .nRST       (nRST),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc),
        .pc_o       (pc_r)
    );

    always_comb begin
        state_d       = state_q;
        pend_pc_d     = pend_pc_q;
        fetch_count_d = fetch_count_q;
        pc_load       = 1'b0;
        pc_load_val   = redir_pc_al;
        pc_inc        = 1'b0;
        deen_raw      = 1'b0;

        if (fe_if.halt) begin
            state_d = HALTED;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (fe_if.redir_valid) begin
                        // On a miss the target is parked so iaddr keeps the outstanding request.
                        if (fe_if.ihit) begin
                            pc_load = 1'b1;
                        end else begin
                            pend_pc_d = redir_pc_al;
                            state_d   = REDIR;
                        end
                    end else if (fe_if.ihit && !fe_if.stall) begin
                        deen_raw      = 1'b1;
                        pc_inc        = 1'b1;
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                end
                REDIR: begin
                    if (fe_if.ihit) begin
                        pc_load     = 1'b1;
                        pc_load_val = fe_if.redir_valid ? redir_pc_al : pend_pc_q;
                        state_d     = FETCH;
                    end else if (fe_if.redir_valid) begin
                        pend_pc_d = redir_pc_al;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= FETCH;
            pend_pc_q     <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_pc_q     <= pend_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fe_if.iREN        = (state_q != HALTED);
    assign fe_if.iaddr       = pc_r;
    assign fe_if.deen        = deen_raw & nRST;
    assign fe_if.instru      = fe_if.iload;
    assign fe_if.PC          = pc_r;
    assign fe_if.nPC         = pc_r + WORD_BYTES;
    assign fe_if.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   checks;
    int   failures;

    fetch_stage_if fif ();

    fetch_stage #(
        .PC_RESET (32'h0000_0000)
    ) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .fe_if (fif.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1ns after the edge, checks 3ns later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic hit, input word_t ld, input logic stl,
                         input logic rv, input word_t rpc, input logic hlt);
        fif.ihit        = hit;
        fif.iload       = ld;
        fif.stall       = stl;
        fif.redir_valid = rv;
        fif.redir_pc    = rpc;
        fif.halt        = hlt;
        #3;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        nRST = 1'b1;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nRST     = 1'b0;
        #1;

        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_iren",  {31'b0, fif.iREN}, 32'd1);
        chk("rst_iaddr", fif.iaddr, 32'h0);
        chk("rst_deen",  {31'b0, fif.deen}, 32'd0);
        chk("rst_instru", fif.instru, 32'hDEAD_BEEF);
        chk("rst_pc",    fif.PC, 32'h0);
        chk("rst_npc",   fif.nPC, 32'h4);
        chk("rst_cnt",   fif.fetch_count, 32'h0);
        do_reset();

        // back-to-back hits
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hA000_0000 + k, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("t1_deen",   {31'b0, fif.deen}, 32'd1);
            chk("t1_pc",     fif.PC, 32'(4 * k));
            chk("t1_npc",    fif.nPC, 32'(4 * k + 4));
            chk("t1_instru", fif.instru, 32'hA000_0000 + k);
            tick();
        end
        #3;
        chk("t1_cnt", fif.fetch_count, 32'd3);

        // miss then hit
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("t2_iaddr", fif.iaddr, 32'h0);
            chk("t2_deen",  {31'b0, fif.deen}, 32'd0);
            tick();
        end
        drive(1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_deen_hit", {31'b0, fif.deen}, 32'd1);
        chk("t2_pc_hit",   fif.PC, 32'h0);
        tick();

        // stall at PC=8
        drive(1'b1, 32'h1111_0004, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h1111_0008, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("t3_deen_stall", {31'b0, fif.deen}, 32'd0);
            chk("t3_pc_stall",   fif.PC, 32'h8);
            tick();
        end
        drive(1'b1, 32'h1111_0008, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_deen", {31'b0, fif.deen}, 32'd1);
        chk("t3_pc",   fif.PC, 32'h8);
        tick();
        drive(1'b1, 32'h1111_000C, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();

        // redirect during a miss, overwritten before the miss resolves
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
        chk("t4_iaddr0", fif.iaddr, 32'h10);
        chk("t4_deen0",  {31'b0, fif.deen}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t4_iaddr1", fif.iaddr, 32'h10);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b0);
        chk("t4_iaddr2", fif.iaddr, 32'h10);
        tick();
        drive(1'b1, 32'h2222_0010, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t4_iaddr3", fif.iaddr, 32'h10);
        chk("t4_deen3",  {31'b0, fif.deen}, 32'd0);
        tick();
        drive(1'b1, 32'h2222_0080, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t4_deen4", {31'b0, fif.deen}, 32'd1);
        chk("t4_pc4",   fif.PC, 32'h80);
        tick();
        #3;
        chk("t4_cnt", fif.fetch_count, 32'd5);

        // redirect on a hit, with unaligned target
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h20, 1'b0);
        tick();
        drive(1'b1, 32'h3333_0020, 1'b1, 1'b1, 32'h123, 1'b0);
        chk("t5_pc",   fif.PC, 32'h20);
        chk("t5_deen", {31'b0, fif.deen}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_iaddr", fif.iaddr, 32'h120);
        chk("t5_cnt",   fif.fetch_count, 32'd5);

        // REDIR resolved by a hit that carries a newer redirect
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h81, 1'b0);
        chk("t5b_deen", {31'b0, fif.deen}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5b_iaddr", fif.iaddr, 32'h80);

        // wrap-around
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        drive(1'b1, 32'h4444_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t7_deen", {31'b0, fif.deen}, 32'd1);
        chk("t7_pc",   fif.PC, 32'hFFFF_FFFC);
        chk("t7_npc",  fif.nPC, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t7_pc_wrap", fif.PC, 32'h0);
        chk("t7_cnt",     fif.fetch_count, 32'd6);

        // halt mid-miss
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_deen_h", {31'b0, fif.deen}, 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h5555_0000, 1'b0, (k == 1), 32'h100, 1'b0);
            chk("t6_iren", {31'b0, fif.iREN}, 32'd0);
            chk("t6_deen", {31'b0, fif.deen}, 32'd0);
            chk("t6_pc",   fif.PC, 32'h0);
            chk("t6_cnt",  fif.fetch_count, 32'd6);
            tick();
        end
        nRST = 1'b0;
        #1;
        chk("t6_rst_iaddr", fif.iaddr, 32'h0);
        chk("t6_rst_iren",  {31'b0, fif.iREN}, 32'd1);
        chk("t6_rst_cnt",   fif.fetch_count, 32'd0);
        tick();
        nRST = 1'b1;
        drive(1'b1, 32'h6666_0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_post_deen", {31'b0, fif.deen}, 32'd1);
        chk("t6_post_pc",   fif.PC, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
